// File: rtl/lm32_line_refill_pkg.sv
// Shared encodings for the line refill sequencer: FSM states and Wishbone burst codes.
package lm32_line_refill_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_TAG   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/lm32_line_refill.sv
// Cache line refill sequencer: invalidate sweep after reset/flush, then one Wishbone
// incrementing burst per miss, writing the data RAM per word and the tag RAM once.
module lm32_line_refill
  import lm32_line_refill_pkg::*;
#(
  parameter int bytes_per_line = 16,
  parameter int index_width    = 8,
  localparam int WPL = bytes_per_line / 4,
  localparam int OW  = $clog2(WPL),
  localparam int TW  = 30 - index_width - OW
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      refill_req_i,
  input  logic [31:0]               refill_addr_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [31:0]               i_adr_o,
  output logic                      i_cyc_o,
  output logic                      i_stb_o,
  output logic [2:0]                i_cti_o,
  output logic [1:0]                i_bte_o,
  input  logic [31:0]               i_dat_i,
  input  logic                      i_ack_i,
  input  logic                      i_err_i,
  output logic                      ram_we_o,
  output logic [index_width+OW-1:0] ram_waddr_o,
  output logic [31:0]               ram_wdata_o,
  output logic                      tag_we_o,
  output logic [index_width-1:0]    tag_waddr_o,
  output logic [TW:0]               tag_wdata_o
);

  // One counter serves as flush index and word offset, so it spans the wider of the two.
  localparam int CW = (index_width > OW) ? index_width : OW;
  localparam logic [OW-1:0] WORD_LAST = OW'(WPL - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [index_width-1:0] idx_q, idx_d;
  logic [TW-1:0]          tag_q, tag_d;
  logic                   bad_q, bad_d;
  logic [OW-1:0]          word;
  logic                   unused_addr;

  assign word        = cnt_q[OW-1:0];
  assign unused_addr = ^refill_addr_i[OW+1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FLUSH;
      cnt_q   <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    bad_d       = bad_q;
    tag_we_o    = 1'b0;
    tag_waddr_o = idx_q;
    tag_wdata_o = {~bad_q, tag_q};
    ram_we_o    = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        tag_we_o    = 1'b1;
        tag_waddr_o = cnt_q[index_width-1:0];
        tag_wdata_o = '0;
        if (&cnt_q[index_width-1:0]) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else if (refill_req_i) begin
          cnt_d   = '0;
          idx_d   = refill_addr_i[OW+2 +: index_width];
          tag_d   = refill_addr_i[31 -: TW];
          bad_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Error takes precedence over a simultaneous ack: the word is discarded.
        if (i_err_i) begin
          bad_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_TAG;
        end else if (i_ack_i) begin
          ram_we_o = 1'b1;
          if (word == WORD_LAST) begin
            cnt_d   = '0;
            state_d = ST_TAG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_TAG: begin
        tag_we_o = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        err_o   = bad_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign i_cyc_o     = (state_q == ST_FETCH);
  assign i_stb_o     = i_cyc_o;
  assign i_adr_o     = {tag_q, idx_q, word, 2'b00};
  assign i_cti_o     = !i_cyc_o ? CTI_CLASSIC : (word == WORD_LAST) ? CTI_END : CTI_INCR;
  assign i_bte_o     = BTE_LINEAR;
  assign ram_waddr_o = {idx_q, word};
  assign ram_wdata_o = i_dat_i;

endmodule

// File: tb/tb_lm32_line_refill.sv
// Directed and randomized refill/flush sequences checked against address arithmetic.
module tb_lm32_line_refill;
  localparam int BPL   = 16;
  localparam int IW    = 8;
  localparam int WPL   = BPL / 4;
  localparam int OW    = $clog2(WPL);
  localparam int TW    = 30 - IW - OW;
  localparam int NSETS = 1 << IW;

  logic              clk = 1'b0;
  logic              rst, flush, req, ack, err;
  logic [31:0]       raddr, dat;
  logic              busy, done, err_o, cyc, stb, ram_we, tag_we;
  logic [31:0]       adr, ram_wdata;
  logic [2:0]        cti;
  logic [1:0]        bte;
  logic [IW+OW-1:0]  ram_waddr;
  logic [IW-1:0]     tag_waddr;
  logic [TW:0]       tag_wdata;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lm32_line_refill #(.bytes_per_line(BPL), .index_width(IW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .refill_req_i(req), .refill_addr_i(raddr),
    .busy_o(busy), .done_o(done), .err_o(err_o),
    .i_adr_o(adr), .i_cyc_o(cyc), .i_stb_o(stb), .i_cti_o(cti), .i_bte_o(bte),
    .i_dat_i(dat), .i_ack_i(ack), .i_err_i(err),
    .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
    .tag_we_o(tag_we), .tag_waddr_o(tag_waddr), .tag_wdata_o(tag_wdata)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  // Land mid-cycle, well after the falling edge and before the next rising edge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic sweep(input logic noise);
    for (int i = 0; i < NSETS; i++) begin
      tick();
      rst   = 1'b0;
      flush = noise && ($urandom_range(1) == 1);
      req   = noise && ($urandom_range(1) == 1);
      raddr = $urandom;
      settle();
      chk("sweep_we",   64'(tag_we),    64'(1));
      chk("sweep_addr", 64'(tag_waddr), 64'(i));
      chk("sweep_data", 64'(tag_wdata), 64'(0));
      chk("sweep_cyc",  64'(cyc),       64'(0));
      chk("sweep_busy", 64'(busy),      64'(1));
    end
    tick();
    flush = 1'b0;
    req   = 1'b0;
    settle();
    chk("sweep_end_busy", 64'(busy),   64'(0));
    chk("sweep_end_we",   64'(tag_we), 64'(0));
  endtask

  // err_w / stall_w < 0 disable the error / stall respectively.
  task automatic refill(input logic [31:0] a, input int err_w, input int stall_w, input int stall_n);
    logic [IW-1:0] idx;
    logic [TW-1:0] tg;
    logic [31:0]   base, eadr;
    logic [2:0]    ecti;
    logic [OW-1:0] wb;
    logic          ok;
    idx  = a[OW+2 +: IW];
    tg   = a[31 -: TW];
    base = a & ~32'(BPL - 1);
    ok   = (err_w < 0);
    tick();
    req = 1'b1; flush = 1'b0; ack = 1'b0; err = 1'b0; raddr = a;
    settle();
    chk("req_idle", 64'(busy), 64'(0));
    for (int w = 0; w < WPL; w++) begin
      wb   = w[OW-1:0];
      eadr = base + 32'(4 * w);
      ecti = (w == WPL - 1) ? 3'b111 : 3'b010;
      if (w == stall_w) begin
        for (int s = 0; s < stall_n; s++) begin
          tick();
          ack = 1'b0; err = 1'b0; dat = $urandom;
          req = ($urandom_range(1) == 1); flush = ($urandom_range(1) == 1);
          settle();
          chk("stall_cyc",   64'(cyc),       64'(1));
          chk("stall_stb",   64'(stb),       64'(1));
          chk("stall_adr",   64'(adr),       64'(eadr));
          chk("stall_cti",   64'(cti),       64'(ecti));
          chk("stall_we",    64'(ram_we),    64'(0));
          chk("stall_waddr", 64'(ram_waddr), 64'({idx, wb}));
          chk("stall_tagwe", 64'(tag_we),    64'(0));
          chk("stall_done",  64'(done),      64'(0));
        end
      end
      tick();
      dat = $urandom;
      req = ($urandom_range(1) == 1); flush = ($urandom_range(1) == 1);
      if (w == err_w) begin
        err = 1'b1;
        ack = ($urandom_range(1) == 1);
        settle();
        chk("err_cyc", 64'(cyc),    64'(1));
        chk("err_adr", 64'(adr),    64'(eadr));
        chk("err_we",  64'(ram_we), 64'(0));
        break;
      end
      ack = 1'b1; err = 1'b0;
      settle();
      chk("word_cyc",   64'(cyc),       64'(1));
      chk("word_stb",   64'(stb),       64'(1));
      chk("word_adr",   64'(adr),       64'(eadr));
      chk("word_cti",   64'(cti),       64'(ecti));
      chk("word_bte",   64'(bte),       64'(0));
      chk("word_we",    64'(ram_we),    64'(1));
      chk("word_waddr", 64'(ram_waddr), 64'({idx, wb}));
      chk("word_wdata", 64'(ram_wdata), 64'(dat));
    end
    tick();
    ack = 1'b0; err = 1'b0; req = 1'b0; flush = 1'b0;
    settle();
    chk("tag_cyc",   64'(cyc),       64'(0));
    chk("tag_we",    64'(tag_we),    64'(1));
    chk("tag_addr",  64'(tag_waddr), 64'(idx));
    chk("tag_data",  64'(tag_wdata), 64'({ok, tg}));
    chk("tag_ramwe", 64'(ram_we),    64'(0));
    chk("tag_done",  64'(done),      64'(0));
    tick();
    settle();
    chk("done_pulse", 64'(done),   64'(1));
    chk("done_err",   64'(err_o),  64'(!ok));
    chk("done_tagwe", 64'(tag_we), 64'(0));
    chk("done_busy",  64'(busy),   64'(1));
    tick();
    settle();
    chk("after_done", 64'(done), 64'(0));
    chk("after_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req = 1'b0; ack = 1'b0; err = 1'b0;
    raddr = '0; dat = '0;
    repeat (3) tick();
    settle();
    chk("rst_cyc",   64'(cyc),    64'(0));
    chk("rst_stb",   64'(stb),    64'(0));
    chk("rst_done",  64'(done),   64'(0));
    chk("rst_err",   64'(err_o),  64'(0));
    chk("rst_ramwe", 64'(ram_we), 64'(0));
    chk("rst_busy",  64'(busy),   64'(1));
    sweep(1'b0);

    refill(32'h0000_1234, -1, -1, 0);
    refill(32'h0000_1234, -1,  2, 5);
    refill(32'h0000_1234,  1, -1, 0);

    tick();
    flush = 1'b1; req = 1'b1; raddr = 32'h0000_1234;
    settle();
    chk("flreq_idle", 64'(busy), 64'(0));
    sweep(1'b1);

    for (int n = 0; n < 24; n++) begin
      int ew;
      ew = ($urandom_range(2) == 0) ? int'($urandom_range(WPL - 1)) : -1;
      refill($urandom, ew, int'($urandom_range(WPL - 1)), int'($urandom_range(4)));
    end

    // Reset arriving while word 2 is on the bus.
    tick();
    req = 1'b1; raddr = 32'h0000_1234; ack = 1'b0; err = 1'b0;
    settle();
    for (int w = 0; w < 2; w++) begin
      tick();
      req = 1'b0; ack = 1'b1; dat = $urandom;
      settle();
    end
    tick();
    rst = 1'b1; ack = 1'b1; dat = $urandom;
    settle();
    chk("midrst_adr", 64'(adr), 64'(32'h0000_1238));
    tick();
    ack = 1'b0;
    sweep(1'b0);
    refill(32'hDEAD_BEEF, -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
